// File: rtl/mult_feeder.sv
// Operand feeder for a multi-cycle signed 3x3 multiplier: buffers {m,q} pairs in a
// FIFO, issues them one at a time, captures the product and guards each call with a watchdog.
module mult_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_m,
  input  logic [2:0] in_q,
  output logic [2:0] M_mult,
  output logic [2:0] Q_mult,
  output logic       start_mul,
  input  logic [5:0] Result_mul,
  input  logic       fin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_result,
  output logic       out_err,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and the offered data is held until the transfer.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;

  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop;
  logic [5:0]    head;

  logic [2:0]    m_q, m_d, q_q, q_d;
  logic [7:0]    wd_q, wd_d;
  logic          ov_q, ov_d;
  logic [5:0]    res_q, res_d;
  logic          err_q, err_d;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // No bypass: a full FIFO refuses a pair even if the head is leaving this cycle.
  assign push  = in_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_m, in_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      wd_q    <= '0;
      ov_q    <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      wd_q    <= wd_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    start_mul = 1'b0;
    m_d       = m_q;
    q_d       = q_q;
    wd_d      = wd_q;
    ov_d      = ov_q;
    res_d     = res_q;
    err_d     = err_q;

    if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Only issue when the result slot is free or being drained this cycle.
        if (!empty && (!ov_q || out_ready)) begin
          pop     = 1'b1;
          m_d     = head[5:3];
          q_d     = head[2:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        start_mul = 1'b1;
        wd_d      = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (fin) begin
          res_d   = Result_mul;
          ov_d    = 1'b1;
          state_d = IDLE;
        end else if (wd_q + 8'd1 == TO) begin
          wd_d    = TO;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready   = !full;
  assign M_mult     = m_q;
  assign Q_mult     = q_q;
  assign out_valid  = ov_q;
  assign out_result = res_q;
  assign out_err    = err_q;
  assign busy       = (state_q != IDLE) || !empty;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mult_feeder.sv
// Directed bench for mult_feeder: a behavioural multiplier model answers start_mul,
// and a scoreboard checks issued operands and products against queues filled at push time.
`define CHK(TAG, OBS, EXP) begin checks++; assert ((OBS) === (EXP)) else begin errors++; $error("FAIL %s: observed=%0h expected=%0h", TAG, (OBS), (EXP)); end end

module tb_mult_feeder;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_m = '0;
  logic [2:0] in_q = '0;
  logic [2:0] M_mult, Q_mult;
  logic       start_mul;
  logic [5:0] Result_mul;
  logic       fin;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [5:0] out_result;
  logic       out_err, busy;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  logic [5:0] exp_q[$];
  logic [5:0] op_q[$];

  // 0: model answers 3 cycles after start, 1: model stays silent, 2: bench drives fin by hand
  int         model_mode = 0;
  int         cd = 0;
  logic [5:0] mres = '0;
  logic       model_fin = 1'b0;
  logic [5:0] model_res = '0;
  logic       man_fin = 1'b0;
  logic [5:0] man_res = '0;
  logic [5:0] mon_e;

  assign fin        = (model_mode == 2) ? man_fin : model_fin;
  assign Result_mul = (model_mode == 2) ? man_res : model_res;

  mult_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_q(in_q),
    .M_mult(M_mult), .Q_mult(Q_mult), .start_mul(start_mul),
    .Result_mul(Result_mul), .fin(fin),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_err(out_err), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] prod(input logic [2:0] m, input logic [2:0] q);
    logic signed [5:0] ms, qs, p;
    ms = $signed(m);
    qs = $signed(q);
    p  = ms * qs;
    return p;
  endfunction

  always @(negedge clk) begin
    model_fin <= 1'b0;
    if (cd == 1) begin
      model_fin <= 1'b1;
      model_res <= mres;
    end
    if (cd > 0) cd <= cd - 1;
    if (start_mul && !reset && model_mode == 0) begin
      cd   <= 3;
      mres <= prod(M_mult, Q_mult);
    end
  end

  // Scoreboard: operands checked on each start pulse, products on each accepted output.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (start_mul) begin
        starts++;
        if (op_q.size() == 0) begin
          checks++; errors++;
          $error("FAIL start_unexpected: observed=start_mul expected=no pending pair");
        end else begin
          mon_e = op_q.pop_front();
          `CHK("start_ops", {M_mult, Q_mult}, mon_e)
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $error("FAIL out_unexpected: observed=%0h expected=no pending product", out_result);
        end else begin
          mon_e = exp_q.pop_front();
          `CHK("result", out_result, mon_e)
        end
      end
    end
  end

  task automatic push(input logic [2:0] m, input logic [2:0] q, input bit want);
    int n;
    n = 0;
    in_m = m; in_q = q; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $error("FAIL push_timeout: observed in_ready=0 expected=1");
    end else begin
      op_q.push_back({m, q});
      if (want) exp_q.push_back(prod(m, q));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input int max, input string tag);
    int n;
    n = 0;
    while (!start_mul && n < max) begin
      @(negedge clk);
      n++;
    end
    `CHK(tag, start_mul, 1'b1)
  endtask

  task automatic wait_out(input int max, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    `CHK(tag, out_valid, 1'b1)
    `CHK("fin_to_valid", fin, 1'b1)
  endtask

  task automatic wait_drain(input int max, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || op_q.size() != 0 || busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    `CHK(tag, exp_q.size() + op_q.size(), 0)
  endtask

  initial begin
    int s0;
    // reset values
    repeat (3) @(negedge clk);
    `CHK("rst_in_ready", in_ready, 1'b1)
    `CHK("rst_start", start_mul, 1'b0)
    `CHK("rst_mq", {M_mult, Q_mult}, 6'd0)
    `CHK("rst_out_valid", out_valid, 1'b0)
    `CHK("rst_out_result", out_result, 6'd0)
    `CHK("rst_err", out_err, 1'b0)
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_state", dbg_state, 2'd0)
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // single product 3 * -2, with latency and hold checks
    out_ready = 1'b0;
    s0 = starts;
    push(3'b011, 3'b110, 1'b1);
    `CHK("lat_c1_start", start_mul, 1'b0)
    `CHK("lat_c1_busy", busy, 1'b1)
    @(negedge clk);
    `CHK("lat_c2_start", start_mul, 1'b1)
    `CHK("lat_c2_m", M_mult, 3'b011)
    `CHK("lat_c2_q", Q_mult, 3'b110)
    @(negedge clk);
    `CHK("start_one_cycle", start_mul, 1'b0)
    wait_out(20, "res1_valid");
    `CHK("res1_value", out_result, 6'b111010)
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      `CHK("res1_hold_valid", out_valid, 1'b1)
      `CHK("res1_hold_value", out_result, 6'b111010)
    end
    `CHK("idle_keeps_m", M_mult, 3'b011)
    `CHK("idle_keeps_q", Q_mult, 3'b110)
    `CHK("res1_starts", starts - s0, 1)
    out_ready = 1'b1;
    @(negedge clk);
    `CHK("res1_consumed", out_valid, 1'b0)

    // -4 * -4 = +16
    push(3'b100, 3'b100, 1'b1);
    wait_out(20, "res2_valid");
    `CHK("res2_value", out_result, 6'b010000)
    @(negedge clk);
    `CHK("res2_consumed", out_valid, 1'b0)

    // backpressure: five pairs with the consumer stalled
    out_ready = 1'b0;
    s0 = starts;
    for (int i = 0; i < 5; i++) begin
      push(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1);
    end
    wait_out(20, "bp_first_valid");
    `CHK("bp_full", in_ready, 1'b0)
    in_m = 3'($urandom_range(0, 7)); in_q = 3'($urandom_range(0, 7)); in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      `CHK("bp_in_ready", in_ready, 1'b0)
      `CHK("bp_no_start", start_mul, 1'b0)
      `CHK("bp_hold_result", out_result, exp_q[0])
    end
    in_valid = 1'b0;
    `CHK("bp_starts_held", starts - s0, 1)
    out_ready = 1'b1;
    wait_drain(200, "bp_drain");
    `CHK("bp_starts", starts - s0, 5)

    // watchdog: first call never answered, second one is
    model_mode = 1;
    push(3'b001, 3'b111, 1'b0);
    push(3'b010, 3'b101, 1'b1);
    wait_start(20, "to_start");
    @(posedge clk);
    model_mode = 0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge clk);
      `CHK("to_err_low", out_err, 1'b0)
    end
    @(negedge clk);
    `CHK("to_err_high", out_err, 1'b1)
    `CHK("to_no_valid", out_valid, 1'b0)
    @(negedge clk);
    `CHK("to_next_issue", start_mul, 1'b1)
    wait_drain(50, "to_drain");
    `CHK("to_err_sticky", out_err, 1'b1)

    // fin during ISSUE must be ignored
    model_mode = 2;
    push(3'b010, 3'b011, 1'b1);
    wait_start(20, "iss_start");
    man_fin = 1'b1; man_res = 6'b101010;
    @(negedge clk);
    man_fin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      `CHK("iss_no_capture", out_valid, 1'b0)
      `CHK("iss_in_wait", dbg_state, 2'd2)
    end
    man_fin = 1'b1; man_res = prod(3'b010, 3'b011);
    @(negedge clk);
    man_fin = 1'b0;
    `CHK("iss_late_valid", out_valid, 1'b1)
    `CHK("iss_late_value", out_result, 6'd6)
    @(negedge clk);
    model_mode = 0;

    // reset in the second WAIT cycle with two pairs queued
    push(3'b011, 3'b011, 1'b1);
    push(3'b001, 3'b001, 1'b1);
    push(3'b010, 3'b010, 1'b1);
    `CHK("rw_state_wait", dbg_state, 2'd2)
    @(posedge clk);
    #2 reset = 1'b1;
    op_q.delete();
    exp_q.delete();
    #1;
    `CHK("rw_in_ready", in_ready, 1'b1)
    `CHK("rw_start", start_mul, 1'b0)
    `CHK("rw_mq", {M_mult, Q_mult}, 6'd0)
    `CHK("rw_out_valid", out_valid, 1'b0)
    `CHK("rw_out_result", out_result, 6'd0)
    `CHK("rw_err", out_err, 1'b0)
    `CHK("rw_busy", busy, 1'b0)
    `CHK("rw_state", dbg_state, 2'd0)
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      `CHK("rw_late_fin_ignored", out_valid, 1'b0)
      `CHK("rw_no_start", start_mul, 1'b0)
    end

    // normal operation after reset
    push(3'b111, 3'b101, 1'b1);
    wait_drain(50, "post_drain");
    `CHK("post_err", out_err, 1'b0)

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed=still running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mult_feeder.md
MULT_FEEDER -- requirements
Module: mult_feeder

Interface
REQ-001 Parameter DEPTH, 4, operand FIFO entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT, 15, max WAIT cycles without fin before abort; 1..255.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair on in_m/in_q is offered.
REQ-006 in_ready  output  1  FIFO can accept a pair this cycle.
REQ-007 in_m  input  3  multiplicand, signed two's complement.
REQ-008 in_q  input  3  multiplier, signed two's complement.
REQ-009 M_mult  output  3  multiplicand driven to the multiplier.
REQ-010 Q_mult  output  3  multiplier operand driven to the multiplier.
REQ-011 start_mul  output  1  one-cycle start pulse to the multiplier.
REQ-012 Result_mul  input  6  signed product from the multiplier.
REQ-013 fin  input  1  multiplier done; Result_mul valid while high.
REQ-014 out_valid  output  1  out_result holds an unconsumed product.
REQ-015 out_ready  input  1  consumer accepts out_result this cycle.
REQ-016 out_result  output  6  captured signed product.
REQ-017 out_err  output  1  sticky timeout flag.
REQ-018 busy  output  1  high whenever FSM is not IDLE or FIFO is non-empty.

Function
REQ-019 FIFO of DEPTH {m,q} entries: push on in_valid && in_ready; in_ready = !full; no bypass, so a full FIFO never pushes, even while popping in the same cycle.
REQ-020 FSM states: IDLE, ISSUE, WAIT.
REQ-021 IDLE -> ISSUE when the FIFO is non-empty and (!out_valid || out_ready); in that cycle pop the head into the M_mult/Q_mult registers.
REQ-022 ISSUE: start_mul = 1 for exactly this cycle; clear the watchdog counter; next state is WAIT unconditionally.
REQ-023 WAIT: on fin = 1, load out_result <= Result_mul, set out_valid, go to IDLE.
REQ-024 WAIT: watchdog increments every cycle with fin = 0; when it reaches TIMEOUT, set out_err, discard the operation (out_valid unchanged), and go to IDLE.
REQ-025 fin is ignored in IDLE and ISSUE.
REQ-026 M_mult/Q_mult hold stable from the pop cycle through the end of WAIT, and retain their value in IDLE.
REQ-027 out_valid clears on out_valid && out_ready unless a capture occurs in the same cycle; out_result is stable while out_valid && !out_ready.
REQ-028 Latency: pair pushed at cycle 0 into empty idle block -> popped at cycle 1, start_mul high at cycle 2, out_valid high the cycle after fin is sampled in WAIT.
REQ-029 Back-to-back: the next IDLE->ISSUE may occur the cycle after a WAIT exit.
REQ-030 out_err, once set, stays set until reset; operation continues normally.

Reset
REQ-031 On reset assertion, immediately and asynchronously: FSM = IDLE, FIFO empty, in_ready = 1, start_mul = 0, M_mult = Q_mult = 0, out_valid = 0, out_result = 0, out_err = 0, busy = 0, watchdog = 0.
REQ-032 Reset during ISSUE or WAIT abandons the in-flight operation; a fin arriving after reset release is ignored, because the FSM is in IDLE.

Verification
REQ-033 Push m=3'b011, q=3'b110; model answers fin with Result_mul=6'b111010 three cycles after start -> exactly one start_mul pulse with M_mult=011, Q_mult=110; out_valid=1, out_result=111010 (-6).
REQ-034 Hold out_ready = 0 and push 5 pairs (DEPTH=4) -> after first result, in_ready drops when 4 entries are queued, no further start_mul, out_result held; release out_ready -> products emerge in push order.
REQ-035 Push m=3'b100, q=3'b100 with model returning 6'b010000 -> out_result=010000 (+16).
REQ-036 Model never raises fin -> out_err rises TIMEOUT (15) WAIT cycles after start_mul, out_valid stays 0, next queued pair issues.
REQ-037 Assert reset in the 2nd WAIT cycle with 2 entries queued -> all outputs at reset values in the same cycle; late fin after release produces no out_valid.
REQ-038 Raise fin in the ISSUE cycle only -> no capture, and the block stays in WAIT until a later fin.
